id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 166 ++++++++++++++++
 tb/tb_id_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: instruction decode stage with register-file bypass from writeback,
// load-use hazard detection, and the ID/EX pipeline register.
module id_stage #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_if_valid,
    input  logic [15:0]      i_if_instr,
    input  logic [15:0]      i_if_pc,
    output logic             o_id_ready,
    output logic [2:0]       o_rs1_addr,
    output logic [2:0]       o_rs2_addr,
    input  logic [15:0]      i_rs1_data,
    input  logic [15:0]      i_rs2_data,
    input  logic             i_wb_we,
    input  logic [2:0]       i_wb_rd,
    input  logic [15:0]      i_wb_data,
    input  logic             i_ex_ready,
    input  logic             i_flush,
    output logic             o_ex_valid,
    output logic [3:0]       o_ex_op,
    output logic [2:0]       o_ex_rd,
    output logic [15:0]      o_ex_a,
    output logic [15:0]      o_ex_b,
    output logic [15:0]      o_ex_sd,
    output logic [15:0]      o_ex_imm,
    output logic [15:0]      o_ex_pc,
    output logic             o_ex_we,
    output logic             o_ex_mem_rd,
    output logic             o_ex_mem_wr,
    output logic             o_ex_illegal,
    output logic [CNT_W-1:0] o_stall_cnt
);

    logic [3:0]  w_op;
    logic [2:0]  w_rd;
    logic [15:0] w_imm;
    logic        w_use_rs1, w_use_rs2, w_rs2_hi, w_b_reg;
    logic        w_we, w_mem_rd, w_mem_wr, w_illegal;
    logic [15:0] w_opa, w_opb, w_b, w_sd;
    logic        w_hazard, w_id_ready, w_accept;

    logic             r_valid;
    logic [3:0]       r_op;
    logic [2:0]       r_rd;
    logic [15:0]      r_a, r_b, r_sd, r_imm, r_pc;
    logic             r_we, r_mem_rd, r_mem_wr, r_illegal;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_op  = i_if_instr[15:12];
    assign w_rd  = i_if_instr[11:9];
    assign w_imm = {{10{i_if_instr[5]}}, i_if_instr[5:0]};

    // Opcode decode: which sources are read, where the second one comes from, control flags
    always_comb begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b0;
        w_rs2_hi  = 1'b0;
        w_b_reg   = 1'b0;
        w_we      = 1'b0;
        w_mem_rd  = 1'b0;
        w_mem_wr  = 1'b0;
        w_illegal = 1'b0;
        case (w_op)
            4'h0, 4'h1, 4'h2, 4'h3: begin
                w_use_rs2 = 1'b1;
                w_b_reg   = 1'b1;
                w_we      = 1'b1;
            end
            4'h4: w_we = 1'b1;
            4'h5: begin
                w_we     = 1'b1;
                w_mem_rd = 1'b1;
            end
            4'h6: begin
                // store data register lives in the rd field
                w_use_rs2 = 1'b1;
                w_rs2_hi  = 1'b1;
                w_mem_wr  = 1'b1;
            end
            4'h7: begin
                w_use_rs2 = 1'b1;
                w_rs2_hi  = 1'b1;
                w_b_reg   = 1'b1;
            end
            default: begin
                w_use_rs1 = 1'b0;
                w_illegal = 1'b1;
            end
        endcase
    end

    assign o_rs1_addr = i_if_instr[8:6];
    assign o_rs2_addr = w_rs2_hi ? i_if_instr[11:9] : i_if_instr[5:3];

    // Writeback lands in the register file at this edge, so forward it now; x0 never forwards
    assign w_opa = (i_wb_we && i_wb_rd != 3'd0 && i_wb_rd == o_rs1_addr) ? i_wb_data : i_rs1_data;
    assign w_opb = (i_wb_we && i_wb_rd != 3'd0 && i_wb_rd == o_rs2_addr) ? i_wb_data : i_rs2_data;
    assign w_b   = w_b_reg ? w_opb : w_imm;
    assign w_sd  = w_mem_wr ? w_opb : 16'd0;

    // A load in EX cannot forward its data yet; hold any consumer of its rd in ID
    assign w_hazard = r_valid && r_mem_rd && (r_rd != 3'd0) && i_if_valid &&
                      ((w_use_rs1 && r_rd == o_rs1_addr) || (w_use_rs2 && r_rd == o_rs2_addr));

    assign w_id_ready = (!r_valid || i_ex_ready) && !w_hazard && !i_flush;
    assign w_accept   = i_if_valid && w_id_ready;
    assign o_id_ready = w_id_ready;

    // ID/EX register: reset > flush > load-use bubble > accept > drain > hold
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid     <= 1'b0;
            r_op        <= '0;
            r_rd        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sd        <= '0;
            r_imm       <= '0;
            r_pc        <= '0;
            r_we        <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_illegal   <= 1'b0;
            r_stall_cnt <= '0;
        end else if (i_flush || (w_hazard && i_ex_ready) || (!w_accept && i_ex_ready)) begin
            // any slot that goes empty carries no side effects
            r_valid   <= 1'b0;
            r_we      <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_illegal <= 1'b0;
            if (!i_flush && w_hazard && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_op      <= w_op;
            r_rd      <= w_rd;
            r_a       <= w_opa;
            r_b       <= w_b;
            r_sd      <= w_sd;
            r_imm     <= w_imm;
            r_pc      <= i_if_pc;
            r_we      <= w_we;
            r_mem_rd  <= w_mem_rd;
            r_mem_wr  <= w_mem_wr;
            r_illegal <= w_illegal;
        end
    end

    assign o_ex_valid   = r_valid;
    assign o_ex_op      = r_op;
    assign o_ex_rd      = r_rd;
    assign o_ex_a       = r_a;
    assign o_ex_b       = r_b;
    assign o_ex_sd      = r_sd;
    assign o_ex_imm     = r_imm;
    assign o_ex_pc      = r_pc;
    assign o_ex_we      = r_we;
    assign o_ex_mem_rd  = r_mem_rd;
    assign o_ex_mem_wr  = r_mem_wr;
    assign o_ex_illegal = r_illegal;
    assign o_stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed scenarios plus a randomized run against a
// table-driven reference of the decode stage.
module tb_id_stage;

    localparam int CW = 4;

    typedef struct packed {
        logic        v;
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [15:0] a, b, sd, imm, pc;
        logic        we, mrd, mwr, ill;
    } slot_t;

    logic          clk;
    logic          rst, if_valid, wb_we, ex_ready, flush;
    logic [15:0]   instr, pc, wb_data;
    logic [2:0]    wb_rd;
    logic          id_ready, ex_valid, ex_we, ex_mem_rd, ex_mem_wr, ex_illegal;
    logic [2:0]    rs1_addr, rs2_addr, ex_rd;
    logic [15:0]   rs1_data, rs2_data, ex_a, ex_b, ex_sd, ex_imm, ex_pc;
    logic [3:0]    ex_op;
    logic [CW-1:0] stall_cnt;
    logic [15:0]   rf [8];

    int checks = 0;
    int failures = 0;

    id_stage #(.CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_if_valid(if_valid), .i_if_instr(instr), .i_if_pc(pc),
        .o_id_ready(id_ready), .o_rs1_addr(rs1_addr), .o_rs2_addr(rs2_addr),
        .i_rs1_data(rs1_data), .i_rs2_data(rs2_data),
        .i_wb_we(wb_we), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .i_ex_ready(ex_ready), .i_flush(flush),
        .o_ex_valid(ex_valid), .o_ex_op(ex_op), .o_ex_rd(ex_rd), .o_ex_a(ex_a), .o_ex_b(ex_b),
        .o_ex_sd(ex_sd), .o_ex_imm(ex_imm), .o_ex_pc(ex_pc), .o_ex_we(ex_we),
        .o_ex_mem_rd(ex_mem_rd), .o_ex_mem_wr(ex_mem_wr), .o_ex_illegal(ex_illegal),
        .o_stall_cnt(stall_cnt)
    );

    // register file model: combinational read, x0 hard-wired to zero
    assign rs1_data = (rs1_addr == 3'd0) ? 16'd0 : rf[rs1_addr];
    assign rs2_data = (rs2_addr == 3'd0) ? 16'd0 : rf[rs2_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic r, input logic iv, input logic [15:0] ins,
                          input logic [15:0] pcv, input logic er, input logic fl);
        rst = r; if_valid = iv; instr = ins; pc = pcv; ex_ready = er; flush = fl;
        wb_we = 1'b0; wb_rd = 3'd0; wb_data = 16'd0;
    endtask

    // one clock; the register file takes the writeback just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (wb_we && wb_rd != 3'd0) rf[wb_rd] = wb_data;
    endtask

    function automatic logic [15:0] opnd(input logic [2:0] s);
        if (s == 3'd0) return 16'd0;
        if (wb_we && wb_rd == s) return wb_data;
        return rf[s];
    endfunction

    // reference: what the ID/EX slot should hold after accepting ins
    function automatic slot_t mdecode(input logic [15:0] ins, input logic [15:0] p);
        slot_t s;
        logic [15:0] imm;
        imm = {{10{ins[5]}}, ins[5:0]};
        s = '0;
        s.v = 1'b1; s.op = ins[15:12]; s.rd = ins[11:9]; s.imm = imm; s.pc = p;
        s.a = opnd(ins[8:6]);
        s.b = imm;
        case (int'(ins[15:12]))
            0, 1, 2, 3: begin s.b = opnd(ins[5:3]); s.we = 1'b1; end
            4:          s.we = 1'b1;
            5:          begin s.we = 1'b1; s.mrd = 1'b1; end
            6:          begin s.sd = opnd(ins[11:9]); s.mwr = 1'b1; end
            7:          s.b = opnd(ins[11:9]);
            default:    s.ill = 1'b1;
        endcase
        return s;
    endfunction

    function automatic bit reads_reg(input logic [15:0] ins, input logic [2:0] r);
        case (int'(ins[15:12]))
            0, 1, 2, 3: return (r == ins[8:6]) || (r == ins[5:3]);
            4, 5:       return r == ins[8:6];
            6, 7:       return (r == ins[8:6]) || (r == ins[11:9]);
            default:    return 1'b0;
        endcase
    endfunction

    task automatic test_reset();
        set_in(1, 1, 16'h0298, 16'h0100, 1, 0);
        tick();
        checks++;
        if ({ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_sd, ex_imm, ex_pc, ex_we, ex_mem_rd,
             ex_mem_wr, ex_illegal, stall_cnt} !== '0)
            begin failures++; $display("FAIL reset_clear: valid=%b a=%h pc=%h stall=%0d, want all 0", ex_valid, ex_a, ex_pc, stall_cnt); end
        set_in(0, 0, 16'h0000, 16'h0000, 1, 0);
        tick();
        checks++;
        if (ex_valid !== 1'b0)
            begin failures++; $display("FAIL reset_idle: ex_valid=%b want 0", ex_valid); end
    endtask

    task automatic test_add();
        rf[2] = 16'd5; rf[3] = 16'd7;
        set_in(0, 1, {4'h0, 3'd1, 3'd2, 3'd3, 3'd0}, 16'h0040, 1, 0);
        #1;
        checks++;
        if ({id_ready, rs1_addr, rs2_addr} !== {1'b1, 3'd2, 3'd3})
            begin failures++; $display("FAIL add_decode: rdy=%b rs1=%0d rs2=%0d want 1 2 3", id_ready, rs1_addr, rs2_addr); end
        tick();
        checks++;
        if ({ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_we, ex_pc} !== {1'b1, 4'h0, 3'd1, 16'd5, 16'd7, 1'b1, 16'h0040})
            begin failures++; $display("FAIL add_result: v=%b op=%h rd=%0d a=%h b=%h we=%b pc=%h", ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_we, ex_pc); end
    endtask

    task automatic test_bypass();
        set_in(0, 1, {4'h4, 3'd1, 3'd2, 6'h3F}, 16'h0042, 1, 0);
        wb_we = 1'b1; wb_rd = 3'd2; wb_data = 16'h0010;
        tick();
        checks++;
        if ({ex_valid, ex_op, ex_a, ex_b, ex_we} !== {1'b1, 4'h4, 16'h0010, 16'hFFFF, 1'b1})
            begin failures++; $display("FAIL wb_bypass: v=%b op=%h a=%h b=%h want 1 4 0010 ffff", ex_valid, ex_op, ex_a, ex_b); end
    endtask

    task automatic test_load_use();
        set_in(1, 0, 16'h0000, 16'h0000, 1, 0);
        tick();
        set_in(0, 1, {4'h5, 3'd4, 3'd1, 6'd0}, 16'h0050, 1, 0);
        tick();
        checks++;
        if ({ex_valid, ex_mem_rd, ex_rd} !== {1'b1, 1'b1, 3'd4})
            begin failures++; $display("FAIL lw_accept: v=%b mrd=%b rd=%0d", ex_valid, ex_mem_rd, ex_rd); end
        set_in(0, 1, {4'h0, 3'd5, 3'd4, 3'd0, 3'd0}, 16'h0052, 1, 0);
        #1;
        checks++;
        if (id_ready !== 1'b0)
            begin failures++; $display("FAIL lu_stall_ready: id_ready=%b want 0", id_ready); end
        tick();
        checks++;
        if ({ex_valid, ex_we, ex_mem_rd, ex_mem_wr, stall_cnt} !== {4'b0000, 4'd1})
            begin failures++; $display("FAIL lu_bubble: v=%b we=%b mrd=%b stall=%0d want 0 0 0 1", ex_valid, ex_we, ex_mem_rd, stall_cnt); end
        checks++;
        if (id_ready !== 1'b1)
            begin failures++; $display("FAIL lu_release: id_ready=%b want 1", id_ready); end
        tick();
        checks++;
        if ({ex_valid, ex_op, ex_rd, ex_pc, stall_cnt} !== {1'b1, 4'h0, 3'd5, 16'h0052, 4'd1})
            begin failures++; $display("FAIL lu_add_accept: v=%b op=%h rd=%0d pc=%h stall=%0d", ex_valid, ex_op, ex_rd, ex_pc, stall_cnt); end
    endtask

    task automatic test_hold();
        rf[2] = 16'h1234; rf[3] = 16'hBEEF;
        set_in(0, 1, {4'h6, 3'd3, 3'd2, 6'h05}, 16'h0060, 1, 0);
        #1;
        checks++;
        if ({rs1_addr, rs2_addr} !== {3'd2, 3'd3})
            begin failures++; $display("FAIL sw_addr: rs1=%0d rs2=%0d want 2 3", rs1_addr, rs2_addr); end
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, {4'h0, 3'd1, 3'd1, 3'd1, 3'd0}, 16'h0062, 0, 0);
            #1;
            checks++;
            if (id_ready !== 1'b0)
                begin failures++; $display("FAIL hold_ready[%0d]: id_ready=%b want 0", i, id_ready); end
            tick();
            checks++;
            if ({ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_sd, ex_imm, ex_pc, ex_we, ex_mem_rd, ex_mem_wr, ex_illegal}
                !== {1'b1, 4'h6, 3'd3, 16'h1234, 16'h0005, 16'hBEEF, 16'h0005, 16'h0060, 4'b0010})
                begin failures++; $display("FAIL hold_stable[%0d]: v=%b op=%h a=%h b=%h sd=%h pc=%h mwr=%b", i, ex_valid, ex_op, ex_a, ex_b, ex_sd, ex_pc, ex_mem_wr); end
        end
    endtask

    task automatic test_flush();
        set_in(0, 1, {4'h0, 3'd1, 3'd2, 3'd3, 3'd0}, 16'h0070, 1, 1);
        #1;
        checks++;
        if (id_ready !== 1'b0)
            begin failures++; $display("FAIL flush_ready: id_ready=%b want 0", id_ready); end
        tick();
        checks++;
        if ({ex_valid, ex_we, ex_mem_rd, ex_mem_wr} !== 4'b0000)
            begin failures++; $display("FAIL flush_kill: v=%b we=%b mrd=%b mwr=%b want 0", ex_valid, ex_we, ex_mem_rd, ex_mem_wr); end
    endtask

    task automatic test_illegal();
        set_in(0, 1, 16'hA123, 16'h0080, 1, 0);
        tick();
        checks++;
        if ({ex_valid, ex_illegal, ex_we, ex_mem_rd, ex_mem_wr} !== 5'b11000)
            begin failures++; $display("FAIL illegal_flags: v=%b ill=%b we=%b mrd=%b mwr=%b", ex_valid, ex_illegal, ex_we, ex_mem_rd, ex_mem_wr); end
        set_in(1, 1, {4'h0, 3'd1, 3'd2, 3'd3, 3'd0}, 16'h0082, 1, 1);
        tick();
        checks++;
        if ({ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_sd, ex_imm, ex_pc, ex_we, ex_mem_rd,
             ex_mem_wr, ex_illegal, stall_cnt} !== '0)
            begin failures++; $display("FAIL illegal_rst: v=%b op=%h ill=%b pc=%h, want all 0", ex_valid, ex_op, ex_illegal, ex_pc); end
    endtask

    task automatic test_reset_mid_stall();
        set_in(0, 1, {4'h5, 3'd4, 3'd1, 6'd2}, 16'h0090, 0, 0);
        tick();
        set_in(0, 1, {4'h0, 3'd5, 3'd4, 3'd4, 3'd0}, 16'h0092, 0, 0);
        tick();
        set_in(1, 1, {4'h0, 3'd5, 3'd4, 3'd4, 3'd0}, 16'h0092, 0, 0);
        tick();
        checks++;
        if ({ex_valid, ex_mem_rd, stall_cnt} !== '0)
            begin failures++; $display("FAIL rst_stall_clear: v=%b mrd=%b stall=%0d want 0", ex_valid, ex_mem_rd, stall_cnt); end
        set_in(0, 1, {4'h0, 3'd5, 3'd4, 3'd4, 3'd0}, 16'h0092, 1, 0);
        tick();
        checks++;
        if ({ex_valid, ex_op, ex_rd, ex_pc, stall_cnt} !== {1'b1, 4'h0, 3'd5, 16'h0092, 4'd0})
            begin failures++; $display("FAIL rst_fresh_accept: v=%b rd=%0d pc=%h stall=%0d", ex_valid, ex_rd, ex_pc, stall_cnt); end
    endtask

    task automatic test_saturate();
        set_in(1, 0, 16'h0000, 16'h0000, 1, 0);
        tick();
        for (int i = 0; i < 17; i++) begin
            set_in(0, 1, {4'h5, 3'd1, 3'd2, 6'd0}, 16'h00A0, 1, 0);
            tick();
            set_in(0, 1, {4'h1, 3'd2, 3'd1, 3'd1, 3'd0}, 16'h00A2, 1, 0);
            tick();
            if (i == 13) begin
                checks++;
                if (stall_cnt !== 4'd14)
                    begin failures++; $display("FAIL stall_count: stall=%0d want 14", stall_cnt); end
            end
        end
        checks++;
        if (stall_cnt !== 4'hF)
            begin failures++; $display("FAIL stall_saturate: stall=%0d want 15", stall_cnt); end
    endtask

    task automatic test_random();
        slot_t m, d;
        int st;
        bit hz, rdy;
        logic [3:0] op;
        set_in(1, 0, 16'h0000, 16'h0000, 1, 0);
        tick();
        m = '0; st = 0;
        for (int c = 0; c < 600; c++) begin
            op = 4'($urandom_range(0, 15));
            if (op >= 4'd10 && op <= 4'd12) op = 4'h5;
            set_in(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 7),
                   {op, 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)), 3'($urandom)},
                   16'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
            wb_we = 1'($urandom); wb_rd = 3'($urandom); wb_data = 16'($urandom);
            #1;
            hz  = m.v && m.mrd && m.rd != 3'd0 && if_valid && reads_reg(instr, m.rd);
            rdy = (!m.v || ex_ready) && !hz && !flush;
            checks++;
            if ({id_ready, rs1_addr, rs2_addr} !== {rdy, instr[8:6], (op == 4'h6 || op == 4'h7) ? instr[11:9] : instr[5:3]})
                begin failures++; $display("FAIL rnd_comb[%0d]: rdy=%b rs1=%0d rs2=%0d want rdy=%b instr=%h", c, id_ready, rs1_addr, rs2_addr, rdy, instr); end
            d = mdecode(instr, pc);
            if (rst) begin
                m = '0; st = 0;
            end else if (flush || (hz && ex_ready) || (!(if_valid && rdy) && ex_ready)) begin
                if (!flush && hz && st < 15) st++;
                m.v = 0; m.we = 0; m.mrd = 0; m.mwr = 0; m.ill = 0;
            end else if (if_valid && rdy) begin
                m = d;
            end
            tick();
            checks++;
            if ({ex_valid, stall_cnt} !== {m.v, 4'(st)})
                begin failures++; $display("FAIL rnd_state[%0d]: v=%b stall=%0d want v=%b stall=%0d", c, ex_valid, stall_cnt, m.v, st); end
            checks++;
            if (m.v) begin
                if ({ex_op, ex_rd, ex_a, ex_b, ex_sd, ex_imm, ex_pc, ex_we, ex_mem_rd, ex_mem_wr, ex_illegal}
                    !== {m.op, m.rd, m.a, m.b, m.sd, m.imm, m.pc, m.we, m.mrd, m.mwr, m.ill})
                    begin failures++; $display("FAIL rnd_slot[%0d]: op=%h a=%h b=%h sd=%h pc=%h f=%b%b%b%b want op=%h a=%h b=%h sd=%h pc=%h f=%b%b%b%b", c, ex_op, ex_a, ex_b, ex_sd, ex_pc, ex_we, ex_mem_rd, ex_mem_wr, ex_illegal, m.op, m.a, m.b, m.sd, m.pc, m.we, m.mrd, m.mwr, m.ill); end
            end else begin
                if ({ex_we, ex_mem_rd, ex_mem_wr} !== 3'b000)
                    begin failures++; $display("FAIL rnd_empty_flags[%0d]: we=%b mrd=%b mwr=%b want 0", c, ex_we, ex_mem_rd, ex_mem_wr); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 16'(i * 16'h0111);
        rf[0] = 16'd0;
        set_in(1, 0, 16'h0000, 16'h0000, 1, 0);
        tick();
        tick();
        test_reset();
        test_add();
        test_bypass();
        test_load_use();
        test_hold();
        test_flush();
        test_illegal();
        test_reset_mid_stall();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
